// File: rtl/cpu_send_arbiter.sv
// cpu_send_arbiter
//   Round-robin arbiter that lets NUM_REQ requesters share one transport send
//   channel. A granted word is held and re-sent until the transport accepts
//   it, with BACKOFF_CYCLES idle cycles after each rejection.
//
// Ports
//   clk, rst        : clock, synchronous active-high reset
//   req_vld/req_data: per-requester valid and 64-bit data (requester i at [64*i +: 64])
//   req_rdy         : one-hot grant, only while idle
//   tx_vld/tx_data/tx_src : send attempt, data and owning requester
//   tx_accept       : transport result, meaningful only while tx_vld=1
//   sent_count      : accepted sends, wrapping 32-bit
//   err_retry       : sticky, set when a transaction collects MAX_RETRY rejects
module cpu_send_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int BACKOFF_CYCLES = 3,
    parameter int MAX_RETRY      = 15
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_vld,
    input  logic [64*NUM_REQ-1:0]      req_data,
    output logic [NUM_REQ-1:0]         req_rdy,
    output logic                       tx_vld,
    output logic [63:0]                tx_data,
    output logic [$clog2(NUM_REQ)-1:0] tx_src,
    input  logic                       tx_accept,
    output logic [31:0]                sent_count,
    output logic                       err_retry
);

    localparam int SRC_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE, SEND, BACKOFF} state_t;

    state_t           state_q, state_d;
    logic [SRC_W-1:0] last_q, last_d;
    logic [SRC_W-1:0] src_q, src_d;
    logic [63:0]      data_q, data_d;
    logic [7:0]       retry_q, retry_d;
    logic [7:0]       bo_q, bo_d;
    logic [31:0]      sent_q, sent_d;
    logic             err_q, err_d;
    logic             tx_vld_q, tx_vld_d;

    logic [NUM_REQ-1:0] grant;
    logic               grant_any;
    logic [SRC_W-1:0]   grant_idx;
    logic [SRC_W-1:0]   scan_idx;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Round-robin search starting one past the last winner. Grants are only
    // offered while idle and never during reset.
    always_comb begin
        grant     = '0;
        grant_any = 1'b0;
        grant_idx = '0;
        scan_idx  = '0;
        if (state_q == IDLE && !rst) begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                scan_idx = SRC_W'((int'(last_q) + k) % NUM_REQ);
                if (!grant_any && req_vld[scan_idx]) begin
                    grant_any = 1'b1;
                    grant_idx = scan_idx;
                end
            end
        end
        grant[grant_idx] = grant_any;
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        src_d   = src_q;
        data_d  = data_q;
        retry_d = retry_q;
        bo_d    = bo_q;
        sent_d  = sent_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (grant_any) begin
                    data_d  = req_data[int'(grant_idx)*64 +: 64];
                    src_d   = grant_idx;
                    last_d  = grant_idx;
                    retry_d = 8'd0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (tx_accept) begin
                    sent_d  = sent_q + 32'd1;
                    state_d = IDLE;
                end else begin
                    retry_d = sat_inc8(retry_q);
                    if (retry_d == 8'(MAX_RETRY)) begin
                        err_d = 1'b1;
                    end
                    // With no backoff the same word is retried back-to-back.
                    if (BACKOFF_CYCLES == 0) begin
                        state_d = SEND;
                    end else begin
                        state_d = BACKOFF;
                        bo_d    = 8'(BACKOFF_CYCLES);
                    end
                end
            end
            BACKOFF: begin
                bo_d = bo_q - 8'd1;
                if (bo_q == 8'd1) begin
                    state_d = SEND;
                end
            end
            default: state_d = IDLE;
        endcase
        tx_vld_d = (state_d == SEND);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            last_q   <= SRC_W'(NUM_REQ - 1);
            src_q    <= '0;
            data_q   <= '0;
            retry_q  <= '0;
            bo_q     <= '0;
            sent_q   <= '0;
            err_q    <= 1'b0;
            tx_vld_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            src_q    <= src_d;
            data_q   <= data_d;
            retry_q  <= retry_d;
            bo_q     <= bo_d;
            sent_q   <= sent_d;
            err_q    <= err_d;
            tx_vld_q <= tx_vld_d;
        end
    end

    assign req_rdy    = grant;
    assign tx_vld     = tx_vld_q;
    assign tx_data    = data_q;
    assign tx_src     = src_q;
    assign sent_count = sent_q;
    assign err_retry  = err_q;

endmodule

// File: tb/tb_cpu_send_arbiter.sv
// Bench for cpu_send_arbiter: directed scenarios plus a randomized run, all
// checked cycle by cycle against a transaction-level reference model.
// A second instance covers the zero-backoff configuration.
module tb_cpu_send_arbiter;

    localparam int N  = 4;
    localparam int BO = 3;
    localparam int MR = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic [N-1:0]     req_vld;
    logic [64*N-1:0]  req_data;
    logic [N-1:0]     req_rdy;
    logic             tx_vld;
    logic [63:0]      tx_data;
    logic [1:0]       tx_src;
    logic             tx_accept;
    logic [31:0]      sent_count;
    logic             err_retry;

    logic             b_rst;
    logic [N-1:0]     b_vld;
    logic [64*N-1:0]  b_data;
    logic [N-1:0]     b_rdy;
    logic             b_tx_vld;
    logic [63:0]      b_tx_data;
    logic [1:0]       b_tx_src;
    logic             b_acc;
    logic [31:0]      b_sent;
    logic             b_err;

    cpu_send_arbiter #(.NUM_REQ(N), .BACKOFF_CYCLES(BO), .MAX_RETRY(MR)) dut (
        .clk(clk), .rst(rst), .req_vld(req_vld), .req_data(req_data),
        .req_rdy(req_rdy), .tx_vld(tx_vld), .tx_data(tx_data), .tx_src(tx_src),
        .tx_accept(tx_accept), .sent_count(sent_count), .err_retry(err_retry)
    );

    cpu_send_arbiter #(.NUM_REQ(N), .BACKOFF_CYCLES(0), .MAX_RETRY(15)) dut_b (
        .clk(clk), .rst(b_rst), .req_vld(b_vld), .req_data(b_data),
        .req_rdy(b_rdy), .tx_vld(b_tx_vld), .tx_data(b_tx_data), .tx_src(b_tx_src),
        .tx_accept(b_acc), .sent_count(b_sent), .err_retry(b_err)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: one pending transaction with a count of idle cycles
    // still owed before its next attempt.
    bit          m_busy;
    int          m_wait;
    int          m_src;
    int          m_last;
    int          m_rej;
    logic [63:0] m_data;
    int unsigned m_sent;
    bit          m_err;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++) begin
            if (v[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_wait = 0; m_src = 0; m_last = N - 1;
        m_rej = 0; m_data = '0; m_sent = 0; m_err = 0;
    endtask

    // One clock: check outputs on the falling edge, advance the model on the
    // rising edge, then optionally drop the request that was just granted.
    task automatic cycle(input bit auto_clear);
        int g;
        bit r;
        logic [N-1:0] erdy;
        @(negedge clk);
        r = rst;
        g = m_busy ? -1 : rr_pick(req_vld, m_last);
        erdy = '0;
        if (!r && g >= 0) erdy[g] = 1'b1;
        chk("req_rdy",    64'(req_rdy),    64'(erdy));
        chk("tx_vld",     64'(tx_vld),     64'(m_busy && m_wait == 0));
        chk("tx_data",    tx_data,         m_data);
        chk("tx_src",     64'(tx_src),     64'(m_src));
        chk("sent_count", 64'(sent_count), 64'(m_sent));
        chk("err_retry",  64'(err_retry),  64'(m_err));
        @(posedge clk);
        if (r) begin
            model_reset();
        end else if (!m_busy) begin
            if (g >= 0) begin
                m_busy = 1; m_wait = 0; m_src = g; m_last = g; m_rej = 0;
                m_data = req_data[64*g +: 64];
            end
        end else if (m_wait == 0) begin
            if (tx_accept) begin
                m_sent++;
                m_busy = 0;
            end else begin
                if (m_rej < 255) m_rej++;
                if (m_rej == MR) m_err = 1;
                m_wait = BO;
            end
        end else begin
            m_wait--;
        end
        #1;
        if (auto_clear && !r && g >= 0) req_vld[g] = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_vld = '0;
        cycle(1'b0);
        rst = 1'b0;
    endtask

    task automatic set_req(input int i, input logic [63:0] d);
        req_vld[i] = 1'b1;
        req_data[64*i +: 64] = d;
    endtask

    initial begin
        logic [63:0] bw;
        rst = 1'b1; req_vld = '0; req_data = '0; tx_accept = 1'b0;
        b_rst = 1'b1; b_vld = '0; b_data = '0; b_acc = 1'b0;
        repeat (2) @(posedge clk);
        model_reset();
        #1;
        // Reset values while rst is held
        do_reset();

        // Single request, accepted first time
        set_req(0, 64'hDEAD_BEEF_0000_0001);
        tx_accept = 1'b1;
        repeat (3) cycle(1'b1);
        chk("single_sent", 64'(sent_count), 64'd1);

        // All four requesting continuously
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, 64'h1111_0000_0000_0000 + 64'(i));
        tx_accept = 1'b1;
        repeat (10) cycle(1'b0);
        chk("rr_sent_after_10", 64'(sent_count), 64'd5);
        chk("rr_fifth_src",     64'(tx_src),     64'd0);
        req_vld = '0;

        // One reject, backoff, then accept
        do_reset();
        set_req(2, 64'hCAFE_0000_0000_0022);
        tx_accept = 1'b0;
        repeat (2) cycle(1'b1);
        tx_accept = 1'b1;
        repeat (4) cycle(1'b1);
        chk("rej_once_sent", 64'(sent_count), 64'd1);
        chk("rej_once_err",  64'(err_retry),  64'd0);

        // Two rejects hit MAX_RETRY, then accept
        do_reset();
        set_req(3, 64'h5555_AAAA_5555_AAAA);
        tx_accept = 1'b0;
        repeat (2) cycle(1'b1);
        chk("one_reject_err", 64'(err_retry), 64'd0);
        repeat (4) cycle(1'b1);
        chk("second_reject_err", 64'(err_retry), 64'd1);
        repeat (3) cycle(1'b1);
        tx_accept = 1'b1;
        cycle(1'b1);
        chk("retry_final_sent", 64'(sent_count), 64'd1);
        chk("retry_final_err",  64'(err_retry),  64'd1);

        // Reset pulse during backoff
        do_reset();
        set_req(1, 64'h0000_0000_0000_0B0B);
        tx_accept = 1'b0;
        repeat (3) cycle(1'b0);
        rst = 1'b1;
        cycle(1'b0);
        chk("rst_bo_vld",  64'(tx_vld),     64'd0);
        chk("rst_bo_sent", 64'(sent_count), 64'd0);
        rst = 1'b0;
        cycle(1'b1);
        chk("rst_bo_src", 64'(tx_src), 64'd1);
        chk("rst_bo_tx",  64'(tx_vld), 64'd1);
        tx_accept = 1'b1;
        cycle(1'b1);

        // Randomized traffic, accepts and occasional resets
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_vld[i] && $urandom_range(0, 2) == 0)
                    set_req(i, {$urandom, $urandom});
            end
            tx_accept = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 99) == 0);
            cycle(1'b1);
        end
        rst = 1'b0;

        // Zero-backoff instance: reject then accept back-to-back
        b_rst = 1'b0;
        bw = 64'h0123_4567_89AB_CDEF;
        b_data[63:0] = bw;
        b_vld = 4'b0001;
        b_acc = 1'b0;
        @(negedge clk);
        chk("b_rdy", 64'(b_rdy), 64'd1);
        @(posedge clk); #1;
        b_vld = '0;
        @(negedge clk);
        chk("b_first_vld", 64'(b_tx_vld), 64'd1);
        chk("b_first_src", 64'(b_tx_src), 64'd0);
        @(posedge clk); #1;
        b_acc = 1'b1;
        @(negedge clk);
        chk("b_retry_vld",  64'(b_tx_vld), 64'd1);
        chk("b_retry_data", b_tx_data, bw);
        @(posedge clk); #1;
        @(negedge clk);
        chk("b_done_vld",  64'(b_tx_vld), 64'd0);
        chk("b_done_sent", 64'(b_sent),   64'd1);
        chk("b_done_err",  64'(b_err),    64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
